// File: rtl/apb_seq_pkg.sv
// Shared types and constants for the two-requester APB sequencer.
package apb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int REQ_N = 2;
    // Holds TIMEOUT_CYCLES - 1 for the supported range 1..63.
    localparam int TO_W  = 6;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; last_grant = 1 means requester 0 wins the next tie.
module rr_arbiter_2
    import apb_seq_pkg::*;
(
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [REQ_N-1:0] valid,
    input  logic             advance,
    output logic [REQ_N-1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = valid;
        if (valid == '1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last_grant <= 1'b1;
        end else if (advance && |valid) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/apb_req_sequencer.sv
// APB master sharing one register slave between two requesters, with per-access timeout.
//   state  | meaning
//   IDLE   | bus quiet, arbitrate and accept a command
//   SETUP  | psel high, command on the bus, load timeout counter
//   ACCESS | penable high, wait for pready or timeout
//   DONE   | bus released, rsp_valid pulse with latched result
module apb_req_sequencer
    import apb_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int AW             = 8,
    parameter int DW             = 8
) (
    input  logic          pclk,
    input  logic          preset_n,
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] select_reg,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          psvlerr
);

    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [TO_W-1:0]  to_cnt;
    logic             cur_id;
    logic [REQ_N-1:0] valid;
    logic [REQ_N-1:0] grant;
    logic             in_idle;

    assign valid   = {req1_valid, req0_valid};
    assign in_idle = (state == IDLE);

    rr_arbiter_2 u_arb (
        .pclk     (pclk),
        .preset_n (preset_n),
        .valid    (valid),
        .advance  (in_idle),
        .grant    (grant)
    );

    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= IDLE;
            to_cnt      <= '0;
            cur_id      <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            select_reg  <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|valid) begin
                        cur_id     <= grant[1];
                        pwrite     <= grant[1] ? req1_write : req0_write;
                        select_reg <= grant[1] ? req1_addr  : req0_addr;
                        pwdata     <= grant[1] ? req1_wdata : req0_wdata;
                        psel       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    to_cnt  <= TO_LOAD;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= psvlerr;
                        rsp_timeout <= 1'b0;
                        state       <= DONE;
                    end else if (to_cnt == '0) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_sequencer.sv
// Self-checking bench: timeline model of each transaction plus directed scenarios.
module tb_apb_req_sequencer;

    localparam int TO = 4;

    logic pclk = 1'b0;
    logic preset_n = 1'b1;

    logic       v [2];
    logic       w [2];
    logic [7:0] a [2];
    logic [7:0] d [2];

    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] select_reg, pwdata;
    logic [7:0] prdata;
    logic       pready, psvlerr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 pclk = ~pclk;

    apb_req_sequencer #(.TIMEOUT_CYCLES(TO), .AW(8), .DW(8)) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .req0_valid  (v[0]),
        .req0_write  (w[0]),
        .req0_addr   (a[0]),
        .req0_wdata  (d[0]),
        .req0_ready  (req0_ready),
        .req1_valid  (v[1]),
        .req1_write  (w[1]),
        .req1_addr   (a[1]),
        .req1_wdata  (d[1]),
        .req1_ready  (req1_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .select_reg  (select_reg),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .psvlerr     (psvlerr)
    );

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act_v, exp_v, $time);
    endtask

    function automatic bit onehot(input logic [7:0] x);
        return $onehot(x);
    endfunction

    function automatic int idx_of(input logic [7:0] x);
        int r = 0;
        for (int i = 0; i < 8; i++) if (x[i]) r = i;
        return r;
    endfunction

    // Register slave: wait_need ACCESS cycles before pready, or never when stalled.
    logic [7:0] smem [8];
    int  k;
    int  wait_need;
    bit  stall;
    bit  spurious;

    always @(negedge pclk) begin
        if (psel && penable) begin
            k++;
            pready = !stall && (k > wait_need);
        end else begin
            k = 0;
            pready = spurious;
        end
        psvlerr = pready && !onehot(select_reg);
        prdata  = onehot(select_reg) ? smem[idx_of(select_reg)] : 8'hEE;
        if (psel && penable && pready && pwrite && onehot(select_reg))
            smem[idx_of(select_reg)] = pwdata;
    end

    // Transaction model: a grant at cycle g with n ACCESS cycles puts psel on
    // g+1..g+1+n, penable on g+2..g+1+n and the response on g+2+n.
    logic [7:0] mmem [8];
    int  cyc = 0;
    int  g, n;
    bit  act = 0;
    bit  last_m = 1;
    bit  e_id, e_w, e_err, e_tmo;
    logic [7:0] e_a, e_d, e_rdata;
    int  glog [$];

    always @(negedge pclk) begin
        bit xp_psel, xp_pen, xp_rsp, xr0, xr1;
        int gid;
        cyc++;
        if (!preset_n) begin
            act    = 0;
            last_m = 1;
        end else begin
            xp_psel = act && cyc >= g + 1 && cyc <= g + 1 + n;
            xp_pen  = act && cyc >= g + 2 && cyc <= g + 1 + n;
            xp_rsp  = act && cyc == g + 2 + n;
            chk("psel", 32'(psel), 32'(xp_psel));
            chk("penable", 32'(penable), 32'(xp_pen));
            chk("rsp_valid", 32'(rsp_valid), 32'(xp_rsp));
            if (xp_psel) begin
                chk("pwrite", 32'(pwrite), 32'(e_w));
                chk("select_reg", 32'(select_reg), 32'(e_a));
                chk("pwdata", 32'(pwdata), 32'(e_d));
            end
            if (xp_rsp) begin
                chk("rsp_id", 32'(rsp_id), 32'(e_id));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e_tmo));
                if (!e_tmo && e_w && onehot(e_a)) mmem[idx_of(e_a)] = e_d;
            end
            if (act && cyc > g + 2 + n) act = 0;
            gid = (v[0] && v[1]) ? (last_m ? 0 : 1) : (v[0] ? 0 : 1);
            xr0 = !act && (v[0] || v[1]) && gid == 0;
            xr1 = !act && (v[0] || v[1]) && gid == 1;
            chk("req0_ready", 32'(req0_ready), 32'(xr0));
            chk("req1_ready", 32'(req1_ready), 32'(xr1));
            if (xr0 || xr1) begin
                glog.push_back(gid);
                last_m = (gid == 1);
                act   = 1;
                g     = cyc;
                e_id  = (gid == 1);
                e_w   = w[gid];
                e_a   = a[gid];
                e_d   = d[gid];
                e_tmo = stall || (wait_need + 1 > TO);
                n     = e_tmo ? TO : wait_need + 1;
                e_err = e_tmo ? 1'b1 : !onehot(e_a);
                if (e_tmo || e_w) e_rdata = 8'h00;
                else e_rdata = onehot(e_a) ? mmem[idx_of(e_a)] : 8'hEE;
            end
        end
    end

    task automatic issue(input int id, input logic wr, input logic [7:0] ad, input logic [7:0] dt);
        bit seen = 0;
        @(posedge pclk); #1;
        w[id] = wr; a[id] = ad; d[id] = dt; v[id] = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge pclk);
            seen = (id == 0) ? req0_ready : req1_ready;
        end
        if (!seen) chk("ready_wait_bound", 32'((id == 0) ? req0_ready : req1_ready), 32'd1);
        @(posedge pclk); #1;
        v[id] = 1'b0;
    endtask

    task automatic wait_rsp(output logic rid, output logic [7:0] rd, output logic er,
                            output logic tm, output int lat, output int acc);
        lat = 0; acc = 0;
        rid = 1'bx; rd = 8'hxx; er = 1'bx; tm = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            lat++;
            if (penable) acc++;
            if (rsp_valid) begin
                rid = rsp_id; rd = rsp_rdata; er = rsp_err; tm = rsp_timeout;
                chk("psel_at_rsp", 32'(psel), 32'd0);
                return;
            end
        end
        chk("rsp_wait_bound", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rid, er, tm;
        logic [7:0] rd;
        int lat, acc, gs, nrsp;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; w[i] = 0; a[i] = 0; d[i] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            smem[i] = 8'h00; mmem[i] = 8'h00;
        end
        stall = 0; spurious = 0; wait_need = 0;
        pready = 0; psvlerr = 0; prdata = 0; k = 0;

        #1 preset_n = 1'b0;
        #3;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_select_reg", 32'(select_reg), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge pclk); @(posedge pclk); #2 preset_n = 1'b1;
        repeat (2) @(posedge pclk);

        // 1: zero-wait write
        issue(0, 1'b1, 8'h04, 8'hA5);
        wait_rsp(rid, rd, er, tm, lat, acc);
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_access_cycles", 32'(acc), 32'd1);
        chk("t1_id", 32'(rid), 32'd0);
        chk("t1_err", 32'(er), 32'd0);

        // 2: read back from the other requester, pready also driven outside ACCESS
        spurious = 1;
        issue(1, 1'b0, 8'h04, 8'h00);
        wait_rsp(rid, rd, er, tm, lat, acc);
        chk("t2_rdata", 32'(rd), 32'hA5);
        chk("t2_id", 32'(rid), 32'd1);
        chk("t2_latency", 32'(lat), 32'd3);

        // 3: simultaneous requests, one wait state each
        wait_need = 1;
        gs = glog.size();
        fork
            issue(0, 1'b1, 8'h01, 8'h11);
            issue(1, 1'b0, 8'h04, 8'h00);
        join
        fork
            issue(0, 1'b0, 8'h01, 8'h00);
            issue(1, 1'b1, 8'h80, 8'h77);
        join
        repeat (12) @(negedge pclk);
        chk("t3_grant_count", 32'(glog.size() - gs), 32'd4);
        if (glog.size() >= gs + 3) begin
            chk("t3_grant0", 32'(glog[gs]), 32'd0);
            chk("t3_grant1", 32'(glog[gs+1]), 32'd1);
            chk("t3_grant2", 32'(glog[gs+2]), 32'd0);
        end
        spurious = 0;
        wait_need = 0;

        // 4: non-one-hot select, slave error
        issue(0, 1'b1, 8'h03, 8'h3C);
        wait_rsp(rid, rd, er, tm, lat, acc);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_timeout", 32'(tm), 32'd0);
        chk("t4_rdata", 32'(rd), 32'd0);

        // 5: pready never arrives
        stall = 1;
        issue(1, 1'b0, 8'h02, 8'h00);
        wait_rsp(rid, rd, er, tm, lat, acc);
        stall = 0;
        chk("t5_access_cycles", 32'(acc), 32'd4);
        chk("t5_err", 32'(er), 32'd1);
        chk("t5_timeout", 32'(tm), 32'd1);
        chk("t5_rdata", 32'(rd), 32'd0);
        chk("t5_id", 32'(rid), 32'd1);

        // 6: reset during ACCESS
        stall = 1;
        issue(0, 1'b1, 8'h08, 8'h99);
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge pclk);
                seen = penable;
            end
            chk("t6_reach_access", 32'(penable), 32'd1);
        end
        #2 preset_n = 1'b0;
        #1;
        chk("t6_psel_async", 32'(psel), 32'd0);
        chk("t6_penable_async", 32'(penable), 32'd0);
        @(negedge pclk); @(negedge pclk);
        #2 preset_n = 1'b1;
        stall = 0;
        nrsp = 0;
        repeat (8) begin
            @(negedge pclk);
            if (rsp_valid) nrsp++;
        end
        chk("t6_no_rsp", 32'(nrsp), 32'd0);
        issue(1, 1'b1, 8'h08, 8'h42);
        wait_rsp(rid, rd, er, tm, lat, acc);
        chk("t6_post_id", 32'(rid), 32'd1);
        chk("t6_post_err", 32'(er), 32'd0);
        chk("t6_post_latency", 32'(lat), 32'd3);
        issue(0, 1'b0, 8'h08, 8'h00);
        wait_rsp(rid, rd, er, tm, lat, acc);
        chk("t6_readback", 32'(rd), 32'h42);

        repeat (3) @(negedge pclk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
